// File: rtl/cassette_recorder.sv
// Cassette recorder: decodes cassette audio periods from the sound DAC into bytes and streams them to SDRAM.
// Optional macro CAS_REC_HYST_EN adds level hysteresis; when it is undefined, the level is taken straight from dac[5].
module cassette_recorder #(
  parameter int          THRESH    = 559,
  parameter int          GAP       = 1023,
  parameter logic [24:0] BASE_ADDR = 25'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Q,
  input  logic        en,
  input  logic        clear,
  input  logic [5:0]  dac,
  output logic [24:0] sdram_addr,
  output logic [7:0]  sdram_data,
  output logic        sdram_we,
  input  logic        sdram_ack,
  output logic [24:0] rec_len,
  output logic        overflow
);

  localparam logic [9:0]  GAP_T    = 10'(GAP);
  localparam logic [9:0]  THRESH_T = 10'(THRESH);
  localparam logic [24:0] ADDR_MAX = '1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t      state;
  logic        lvl;
  logic [9:0]  timer;
  logic [2:0]  cnt;
  logic [7:0]  shift;
  logic        full;
  logic        clear_pend;

  logic        lvl_next;
  logic [9:0]  timer_inc;
  logic        edge_hit;
  logic        gap_hit;
  logic        bit_val;
  logic        byte_done;
  logic [7:0]  byte_val;

  always_comb begin
    lvl_next = lvl;
`ifdef CAS_REC_HYST_EN
    if (dac >= 6'd36)      lvl_next = 1'b1;
    else if (dac <= 6'd27) lvl_next = 1'b0;
`else
    lvl_next = (dac >= 6'd32);
`endif
    // Period is counted inclusive of the edge tick, saturating at GAP.
    timer_inc = (timer >= GAP_T) ? GAP_T : timer + 10'd1;
    edge_hit  = Q && en && !lvl && lvl_next;
    gap_hit   = edge_hit && (timer_inc == GAP_T);
    bit_val   = (timer_inc < THRESH_T);
    byte_done = edge_hit && !gap_hit && (cnt == 3'd7);
    byte_val  = {bit_val, shift[7:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lvl   <= 1'b0;
      timer <= GAP_T;
      cnt   <= 3'd0;
      shift <= 8'd0;
    end else begin
      if (Q) lvl <= lvl_next;
      // With the motor off the decoder sits in a resync state.
      if (!en) begin
        timer <= GAP_T;
        cnt   <= 3'd0;
        shift <= 8'd0;
      end else if (Q) begin
        if (edge_hit) begin
          timer <= 10'd0;
          if (gap_hit) begin
            cnt   <= 3'd0;
            shift <= 8'd0;
          end else begin
            cnt   <= cnt + 3'd1;
            shift <= (cnt == 3'd7) ? 8'd0 : byte_val;
          end
        end else begin
          timer <= timer_inc;
        end
      end
    end
  end

  // Handshake: sdram_we high holds sdram_addr/sdram_data stable until a one-clk
  // sdram_ack accepts the byte; sdram_ack while sdram_we is low is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sdram_we   <= 1'b0;
      sdram_addr <= BASE_ADDR;
      sdram_data <= 8'd0;
      rec_len    <= 25'd0;
      overflow   <= 1'b0;
      full       <= 1'b0;
      clear_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear || clear_pend) begin
            sdram_addr <= BASE_ADDR;
            rec_len    <= 25'd0;
            overflow   <= 1'b0;
            full       <= 1'b0;
            clear_pend <= 1'b0;
          end
          if (byte_done) begin
            if (full && !(clear || clear_pend)) begin
              overflow <= 1'b1;
            end else begin
              sdram_data <= byte_val;
              sdram_we   <= 1'b1;
              state      <= WRITE;
            end
          end
        end
        WRITE: begin
          if (clear) clear_pend <= 1'b1;
          if (sdram_ack) begin
            rec_len <= rec_len + 25'd1;
            if (sdram_addr == ADDR_MAX) full <= 1'b1;
            else                        sdram_addr <= sdram_addr + 25'd1;
            // A byte finishing on the accept cycle chains straight into the next write.
            if (byte_done && (sdram_addr != ADDR_MAX)) begin
              sdram_data <= byte_val;
            end else begin
              if (byte_done) overflow <= 1'b1;
              sdram_we <= 1'b0;
              state    <= IDLE;
            end
          end else if (byte_done) begin
            overflow <= 1'b1;
          end
        end
        default: begin
          sdram_we <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cassette_recorder.sv
// Bench for cassette_recorder: directed scenarios plus randomized periods, with a
// period-to-byte reference model and an expected-write queue.
module tb_cassette_recorder;

  localparam int          THRESH = 559;
  localparam int          GAP    = 1023;
  localparam logic [24:0] BASE   = 25'h0;
`ifdef CAS_REC_HYST_EN
  localparam bit HYST = 1'b1;
`else
  localparam bit HYST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, Q, en, clear, sdram_ack;
  logic [5:0]  dac;
  logic [24:0] sdram_addr, rec_len;
  logic [7:0]  sdram_data;
  logic        sdram_we, overflow;

  int          passed = 0;
  int          total  = 0;
  logic [7:0]  exp_q[$];
  int          m_cnt, m_acc, m_len;
  bit          m_pend, m_ovf, auto_ack;

  cassette_recorder #(.THRESH(THRESH), .GAP(GAP), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .Q(Q), .en(en), .clear(clear), .dac(dac),
    .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_we(sdram_we),
    .sdram_ack(sdram_ack), .rec_len(rec_len), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock; acknowledges an outstanding write when auto_ack is set.
  task automatic step(input logic q);
    logic [24:0] a;
    logic [7:0]  d;
    logic [31:0] e;
    Q = q;
    sdram_ack = auto_ack && sdram_we;
    a = sdram_addr;
    d = sdram_data;
    @(posedge clk);
    #1;
    if (sdram_ack) begin
      if (exp_q.size() > 0) e = {24'd0, exp_q.pop_front()};
      else                  e = 32'hDEAD;
      chk("wr_data", {24'd0, d}, e);
      chk("wr_addr", {7'd0, a}, {7'd0, BASE + 25'(m_len)});
      m_len++;
    end
    sdram_ack = 1'b0;
  endtask

  task automatic tick();
    step(1'b1);
    step(1'b0);
  endtask

  task automatic byte_out(input logic [7:0] b);
    if (auto_ack || !m_pend) begin
      exp_q.push_back(b);
      if (!auto_ack) m_pend = 1'b1;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  // Rising edges p ticks apart; the model classifies the period before the edge tick.
  task automatic period(input int p, input logic [5:0] hi, input logic [5:0] lo, input bit counts);
    for (int k = 1; k < p; k++) begin
      dac = (k < p / 2) ? hi : lo;
      tick();
    end
    if (counts) begin
      if (p >= GAP) begin
        m_cnt = 0;
        m_acc = 0;
      end else begin
        if (p < THRESH) m_acc = m_acc | (1 << m_cnt);
        m_cnt++;
        if (m_cnt == 8) begin
          byte_out(m_acc[7:0]);
          m_cnt = 0;
          m_acc = 0;
        end
      end
    end
    dac = hi;
    tick();
  endtask

  // Motor off/on, then a single resync edge.
  task automatic restart();
    en = 1'b0;
    dac = 6'd4;
    tick();
    tick();
    en = 1'b1;
    tick();
    m_cnt = 0;
    m_acc = 0;
    dac = 6'd60;
    tick();
  endtask

  task automatic idle_ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    reset = 1'b1; Q = 1'b0; en = 1'b0; clear = 1'b0; sdram_ack = 1'b0; dac = 6'd4;
    auto_ack = 1'b1; m_cnt = 0; m_acc = 0; m_len = 0; m_pend = 1'b0; m_ovf = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("rst_we", sdram_we, 0);
    chk("rst_addr", sdram_addr, BASE);
    chk("rst_data", sdram_data, 0);
    chk("rst_len", rec_len, 0);
    chk("rst_ovf", overflow, 0);
    step(1'b0); step(1'b0); step(1'b0);
    reset = 1'b1;
    step(1'b0);

    // Scenario 1: 745-tick periods give 8'h00
    restart();
    for (int i = 0; i < 8; i++) period(745, 6'd60, 6'd4, 1'b1);
    idle_ticks(3);
    chk("s1_drained", exp_q.size(), 0);
    chk("s1_len", rec_len, m_len);
    chk("s1_ovf", overflow, m_ovf);

    // Scenario 2: alternating 372/745 gives 8'h55
    restart();
    for (int i = 0; i < 8; i++) period((i % 2 == 0) ? 372 : 745, 6'd60, 6'd4, 1'b1);
    idle_ticks(3);
    chk("s2_drained", exp_q.size(), 0);
    chk("s2_len", rec_len, m_len);
    chk("s2_ovf", overflow, m_ovf);

    // Random periods with the 558/559 threshold boundary forced in
    restart();
    for (int i = 0; i < 8; i++) begin
      int p;
      p = (i == 2) ? 558 : (i == 5) ? 559 : int'($urandom_range(150, 1000));
      period(p, 6'd60, 6'd4, 1'b1);
    end
    idle_ticks(3);
    chk("rnd_drained", exp_q.size(), 0);
    chk("rnd_len", rec_len, m_len);

    // Gap mid-byte resyncs and discards the partial byte
    restart();
    for (int i = 0; i < 3; i++) period(100, 6'd60, 6'd4, 1'b1);
    period(1100, 6'd60, 6'd4, 1'b1);
    for (int i = 0; i < 8; i++) period($urandom_range(0, 1) ? 100 : 600, 6'd60, 6'd4, 1'b1);
    idle_ticks(3);
    chk("gap_drained", exp_q.size(), 0);
    chk("gap_len", rec_len, m_len);

    // Scenario 4: motor drop after 5 bits, then a full 8'hFF
    restart();
    for (int i = 0; i < 5; i++) period(100, 6'd60, 6'd4, 1'b1);
    restart();
    for (int i = 0; i < 8; i++) period(100, 6'd60, 6'd4, 1'b1);
    idle_ticks(3);
    chk("s4_drained", exp_q.size(), 0);
    chk("s4_len", rec_len, m_len);
    chk("s4_ovf", overflow, m_ovf);

    // Clear in IDLE
    clear = 1'b1; step(1'b0); clear = 1'b0;
    m_len = 0; m_ovf = 1'b0;
    step(1'b0);
    chk("clr_len", rec_len, m_len);
    chk("clr_addr", sdram_addr, BASE);

    // Scenario 3: ack withheld over two bytes, pending clear during WRITE
    auto_ack = 1'b0;
    restart();
    for (int i = 0; i < 16; i++) period(100, 6'd60, 6'd4, 1'b1);
    idle_ticks(3);
    chk("s3_we", sdram_we, m_pend);
    chk("s3_ovf", overflow, m_ovf);
    chk("s3_len", rec_len, m_len);
    clear = 1'b1; step(1'b0); clear = 1'b0;
    chk("s3_clr_held", overflow, m_ovf);
    auto_ack = 1'b1; step(1'b0); auto_ack = 1'b0; m_pend = 1'b0;
    chk("s3_ack_len", rec_len, m_len);
    chk("s3_ack_we", sdram_we, 0);
    step(1'b0);
    m_len = 0; m_ovf = 1'b0;
    chk("s3_pend_len", rec_len, m_len);
    chk("s3_pend_ovf", overflow, m_ovf);
    chk("s3_pend_addr", sdram_addr, BASE);

    // Scenario 5: reset mid-WRITE
    auto_ack = 1'b1;
    restart();
    for (int i = 0; i < 8; i++) period(100, 6'd60, 6'd4, 1'b1);
    auto_ack = 1'b0;
    restart();
    for (int i = 0; i < 8; i++) period(100, 6'd60, 6'd4, 1'b1);
    idle_ticks(2);
    chk("s5_we_pre", sdram_we, m_pend);
    chk("s5_len_pre", rec_len, m_len);
    #2 reset = 1'b0;
    #1;
    exp_q.delete(); m_len = 0; m_pend = 1'b0; m_ovf = 1'b0;
    chk("s5_we", sdram_we, 0);
    chk("s5_len", rec_len, m_len);
    chk("s5_addr", sdram_addr, BASE);
    chk("s5_ovf", overflow, m_ovf);
    #2 reset = 1'b1;
    auto_ack = 1'b1;

    // Scenario 6: dac toggling 31/32 each period
    restart();
    for (int i = 0; i < 8; i++) period(2, 6'd32, 6'd31, !HYST);
    idle_ticks(3);
    chk("s6_drained", exp_q.size(), 0);
    chk("s6_len", rec_len, m_len);
    chk("s6_ovf", overflow, m_ovf);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cassette_recorder.md
CASSETTE_RECORDER -- requirements
Module: cassette_recorder

Interface
REQ-001 SHALL have parameter THRESH, default 559, Q-tick period boundary; period < THRESH decodes as bit 1, otherwise bit 0.
REQ-002 SHALL have parameter GAP, default 1023, Q-tick count at which the period timer saturates and a gap is declared.
REQ-003 SHALL have parameter BASE_ADDR, default 25'h0, first byte address of a recording.
REQ-004 SHALL have port clk, input, 1, system clock (57.272 MHz).
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port Q, input, 1, one-clk-wide tick from the core, about 894.886 kHz.
REQ-007 SHALL have port en, input, 1, cassette motor relay; recording is active while high.
REQ-008 SHALL have port clear, input, 1, one-clk pulse that rewinds the write address to BASE_ADDR and clears overflow.
REQ-009 SHALL have port dac, input, 6, core sound DAC value.
REQ-010 SHALL have port sdram_addr, output, 25, write address.
REQ-011 SHALL have port sdram_data, output, 8, write byte.
REQ-012 SHALL have port sdram_we, output, 1, write request.
REQ-013 SHALL have port sdram_ack, input, 1, one-clk write-accept pulse.
REQ-014 SHALL have port rec_len, output, 25, count of bytes accepted since the last clear.
REQ-015 SHALL have port overflow, output, 1, sticky dropped-byte flag.

Function
REQ-016 SHALL maintain a level register lvl: set when dac >= 36, cleared when dac <= 27, otherwise held; lvl SHALL update only on Q ticks.
REQ-017 SHALL count Q ticks in a 10-bit period timer that saturates at GAP.
REQ-018 On a lvl 0->1 transition while en=1, SHALL classify the timer value as a bit per REQ-001 and then restart the timer at 0.
REQ-019 If the timer value at a rising edge equals GAP, the edge SHALL NOT produce a bit; it SHALL clear the bit counter and the shift register (resync).
REQ-020 SHALL shift bits LSB-first into an 8-bit shift register with a 3-bit counter; a completed 8th bit SHALL form a byte in the same clk.
REQ-021 Write FSM states: IDLE (sdram_we=0) and WRITE (sdram_we=1, sdram_addr and sdram_data stable).
REQ-022 A completed byte in IDLE SHALL latch into the buffer and enter WRITE on the next clk.
REQ-023 In WRITE, sdram_ack SHALL increment sdram_addr and rec_len and return the FSM to IDLE.
REQ-024 A byte completed in WRITE without a same-cycle ack SHALL be dropped and SHALL set overflow.
REQ-025 A byte completed in the same clk as sdram_ack SHALL be latched, with the FSM staying in WRITE and no overflow.
REQ-026 sdram_addr SHALL saturate at 25'h1FFFFFF; a further completed byte SHALL set overflow and SHALL NOT be written.
REQ-027 When en falls, SHALL discard any partial byte, reset the bit counter, and hold the timer at GAP; a pending WRITE SHALL complete.
REQ-028 When en rises, SHALL start the timer saturated at GAP so that the first edge only resyncs.
REQ-029 clear SHALL take effect only in IDLE; a clear arriving in WRITE SHALL be held pending until the FSM returns to IDLE.

Reset
REQ-030 Asserting reset (low) SHALL asynchronously force FSM=IDLE, sdram_we=0, sdram_addr=BASE_ADDR, sdram_data=0, rec_len=0, overflow=0, lvl=0, timer=GAP, counter=0, shift=0.
REQ-031 A reset asserted during WRITE SHALL abandon the write without raising overflow.

Configuration
REQ-032 Macro CAS_REC_HYST_EN defined SHALL give the REQ-016 hysteresis; undefined, SHALL give lvl = dac[5] sampled on Q with no hysteresis.

Verification
REQ-033 Scenario 1: en=1, sine-like dac square 60/4 with 745-tick periods x9 (first edge resyncs) -> one byte 8'h00 written at BASE_ADDR, rec_len=1.
REQ-034 Scenario 2: 1 resync edge then periods 372,745,372,745,372,745,372,745 -> byte 8'h55 written, overflow=0.
REQ-035 Scenario 3: sdram_ack withheld for 2 byte-times -> first byte remains in WRITE, second byte dropped, overflow=1, rec_len unchanged until ack.
REQ-036 Scenario 4: en dropped after 5 bits then re-raised with a full 8'hFF -> only 8'hFF written, no partial byte.
REQ-037 Scenario 5: reset pulsed low mid-WRITE -> sdram_we=0 immediately (asynchronously), rec_len=0, sdram_addr=BASE_ADDR.
REQ-038 Scenario 6: without CAS_REC_HYST_EN, dac toggling 31/32 per tick -> lvl follows dac[5]; with the macro defined, lvl does not change.
